// File: rtl/mc_pkg.sv
// mc_pkg -- shared encodings for the multicycle_ctrl sequencer.
//   Opcodes of the 8-bit model machine (ir[7:4]), the FSM state encoding,
//   AU function codes, RAM address select codes, and helpers that derive
//   the register-file source/destination selects from an instruction word.
package mc_pkg;

   // Opcodes (ir[7:4]); 0000-0011 are NOPs
   localparam logic [3:0] OP_MOVA = 4'b0100;
   localparam logic [3:0] OP_MOVB = 4'b0101;
   localparam logic [3:0] OP_MOVC = 4'b0110;
   localparam logic [3:0] OP_MOVD = 4'b0111;
   localparam logic [3:0] OP_ADD  = 4'b1000;
   localparam logic [3:0] OP_SUB  = 4'b1001;
   localparam logic [3:0] OP_JMP  = 4'b1010;
   localparam logic [3:0] OP_JG   = 4'b1011;
   localparam logic [3:0] OP_IN   = 4'b1100;
   localparam logic [3:0] OP_OUT  = 4'b1101;
   localparam logic [3:0] OP_MOVI = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_DECODE   = 3'd2,
      ST_EXEC     = 3'd3,
      ST_IN_WAIT  = 3'd4,
      ST_OUT_WAIT = 3'd5,
      ST_PAUSE    = 3'd6,
      ST_HALT     = 3'd7
   } state_e;

   // AU function codes
   localparam logic [3:0] AC_NONE = 4'b0000;
   localparam logic [3:0] AC_PASS = 4'b0100;
   localparam logic [3:0] AC_ADD  = 4'b1000;
   localparam logic [3:0] AC_SUB  = 4'b1001;

   // RAM address select
   localparam logic [1:0] S_PC = 2'b00;
   localparam logic [1:0] S_RS = 2'b01;
   localparam logic [1:0] S_RD = 2'b10;

   // Jumps and MOVD take their operand (target / address) from R3.
   function automatic logic [1:0] src_sel(input logic [7:0] instr);
      logic [3:0] op;
      op = instr[7:4];
      if ((op == OP_JMP) || (op == OP_JG) || (op == OP_MOVD)) begin
         return 2'b11;
      end else begin
         return instr[1:0];
      end
   endfunction

   // MOVI always loads R0; MOVD always loads R3.
   function automatic logic [1:0] dst_sel(input logic [7:0] instr);
      logic [1:0] dr;
      case (instr[7:4])
         OP_MOVI: dr = 2'b00;
         OP_MOVD: dr = 2'b11;
         default: dr = instr[3:2];
      endcase
      return dr;
   endfunction

endpackage

// File: rtl/io_wait_timer.sv
// io_wait_timer -- cycle counter for the IN/OUT wait states.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : return the count to zero (held while not waiting)
//   en_i       : count one wait cycle
//   expired_o  : high during the TIMEOUT-th enabled cycle since clear;
//                never high when TIMEOUT is 0
module io_wait_timer #(
   parameter int TMR_W   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic             TMO_ON   = (TIMEOUT > 0);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   // Next count: clear has priority over counting
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {TMR_W{1'b0}};
      end else if (en_i) begin
         cnt_d = cnt_q + TMR_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {TMR_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The count reads k-1 in the k-th wait cycle, so TIMEOUT-1 marks the last one.
   assign expired_o = TMO_ON & en_i & (cnt_q == TMR_LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- FETCH/DECODE/EXEC sequencer for the 8-bit model machine.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, step_mode     : run control (start from IDLE/PAUSE/HALT, pause per instr)
//   ir, gf               : datapath instruction register and G flag
//   in_valid / in_ack    : input handshake (in_ack pulses on acceptance)
//   out_valid / out_ready: output handshake
//   ld_pc..s0, s, ac, SR, DR : datapath control strobes and selects
//   busy, halted, io_err : status (io_err is sticky until restart from HALT)
//   instr_cnt            : retired-instruction count, wraps
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255,
   parameter int TMR_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             step_mode,
   input  logic [7:0]       ir,
   input  logic             gf,
   input  logic             in_valid,
   output logic             in_ack,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ld_pc,
   output logic             in_pc,
   output logic             ram_we,
   output logic             ram_re,
   output logic             ld_ir,
   output logic             reg_we,
   output logic             au_en,
   output logic             g_en,
   output logic             in_en,
   output logic             out_en,
   output logic             s0,
   output logic [1:0]       s,
   output logic [3:0]       ac,
   output logic [1:0]       SR,
   output logic [1:0]       DR,
   output logic             busy,
   output logic             halted,
   output logic             io_err,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q;
   state_e           state_d;
   state_e           done_st;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             err_q;
   logic             err_d;

   logic [3:0]       op;
   logic             in_wait;
   logic             out_wait;
   logic             io_wait;
   logic             in_hs;
   logic             out_hs;
   logic             tmo_exp;
   logic             tmo_fire;
   logic             retire;

   assign op       = ir[7:4];
   assign in_wait  = (state_q == ST_IN_WAIT);
   assign out_wait = (state_q == ST_OUT_WAIT);
   assign io_wait  = in_wait | out_wait;
   assign in_hs    = in_wait & in_valid;
   assign out_hs   = out_wait & out_ready;
   // A handshake in the expiring cycle still completes the transfer.
   assign tmo_fire = io_wait & tmo_exp & ~in_hs & ~out_hs;
   // HALT retires in DECODE; everything else retires on its last cycle.
   assign retire   = (state_q == ST_EXEC) | in_hs | out_hs |
                     ((state_q == ST_DECODE) & (op == OP_HALT));
   assign done_st  = step_mode ? ST_PAUSE : ST_FETCH;

   // Timer is held clear outside the wait states, so each wait starts from zero.
   io_wait_timer #(
      .TMR_W   (TMR_W),
      .TIMEOUT (TIMEOUT)
   ) u_io_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (~io_wait),
      .en_i      (io_wait),
      .expired_o (tmo_exp)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = start ? ST_FETCH : ST_IDLE;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            case (op)
               OP_IN:   state_d = ST_IN_WAIT;
               OP_OUT:  state_d = ST_OUT_WAIT;
               OP_HALT: state_d = ST_HALT;
               default: state_d = ST_EXEC;
            endcase
         end
         ST_EXEC:   state_d = done_st;
         ST_IN_WAIT: begin
            if (in_hs) begin
               state_d = done_st;
            end else if (tmo_fire) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_IN_WAIT;
            end
         end
         ST_OUT_WAIT: begin
            if (out_hs) begin
               state_d = done_st;
            end else if (tmo_fire) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_OUT_WAIT;
            end
         end
         ST_PAUSE:  state_d = start ? ST_FETCH : ST_PAUSE;
         ST_HALT:   state_d = start ? ST_FETCH : ST_HALT;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output decode from the current state (and ir/gf/in_valid where needed)
   always_comb begin
      ld_pc     = 1'b0;
      in_pc     = 1'b0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ld_ir     = 1'b0;
      reg_we    = 1'b0;
      au_en     = 1'b0;
      g_en      = 1'b0;
      in_en     = 1'b0;
      out_en    = 1'b0;
      in_ack    = 1'b0;
      out_valid = 1'b0;
      s0        = 1'b1;
      s         = S_PC;
      ac        = AC_NONE;
      SR        = 2'b00;
      DR        = 2'b00;
      busy      = 1'b0;
      halted    = 1'b0;
      case (state_q)
         ST_FETCH: begin
            busy   = 1'b1;
            ram_re = 1'b1;
            s      = S_PC;
            ld_ir  = 1'b1;
            in_pc  = 1'b1;
         end
         ST_DECODE: begin
            busy = 1'b1;
            SR   = src_sel(ir);
            DR   = dst_sel(ir);
         end
         ST_EXEC: begin
            busy = 1'b1;
            SR   = src_sel(ir);
            DR   = dst_sel(ir);
            case (op)
               OP_MOVA: begin
                  au_en  = 1'b1;
                  ac     = AC_PASS;
                  reg_we = 1'b1;
               end
               OP_MOVB: begin
                  au_en  = 1'b1;
                  ac     = AC_PASS;
                  s      = S_RD;
                  ram_we = 1'b1;
               end
               OP_MOVC: begin
                  s      = S_RS;
                  ram_re = 1'b1;
                  reg_we = 1'b1;
               end
               OP_MOVD: begin
                  s0     = 1'b0;
                  reg_we = 1'b1;
               end
               OP_ADD: begin
                  au_en  = 1'b1;
                  ac     = AC_ADD;
                  reg_we = 1'b1;
               end
               OP_SUB: begin
                  au_en  = 1'b1;
                  ac     = AC_SUB;
                  reg_we = 1'b1;
                  g_en   = 1'b1;
               end
               OP_JMP:  ld_pc = 1'b1;
               OP_JG:   ld_pc = gf;
               OP_MOVI: begin
                  ram_re = 1'b1;
                  s      = S_PC;
                  in_pc  = 1'b1;
                  reg_we = 1'b1;
               end
               default: ld_pc = 1'b0;
            endcase
         end
         ST_IN_WAIT: begin
            busy   = 1'b1;
            SR     = src_sel(ir);
            DR     = dst_sel(ir);
            reg_we = in_valid;
            in_en  = in_valid;
            in_ack = in_valid;
         end
         ST_OUT_WAIT: begin
            busy      = 1'b1;
            SR        = src_sel(ir);
            DR        = dst_sel(ir);
            au_en     = 1'b1;
            ac        = AC_PASS;
            out_en    = 1'b1;
            out_valid = 1'b1;
         end
         ST_HALT:  halted = 1'b1;
         default:  busy   = 1'b0;
      endcase
   end

   // Retired-count and sticky error next values
   always_comb begin
      cnt_d = retire ? (cnt_q + CNT_ONE) : cnt_q;
      if (tmo_fire) begin
         err_d = 1'b1;
      end else if ((state_q == ST_HALT) && start) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // Retired-count and sticky error registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CNT_W{1'b0}};
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign instr_cnt = cnt_q;
   assign io_err    = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl -- scoreboard bench for multicycle_ctrl.
//   The driver plays the program one cycle at a time and, from a
//   per-instruction timing model (phases, handshake delay, timeout), pushes
//   the control vector, count and error flag expected for every cycle.
//   A monitor on the falling edge pops and compares.
module tb_multicycle_ctrl;

   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 5;
   localparam int TMR_W   = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             step_mode;
   logic [7:0]       ir;
   logic             gf;
   logic             in_valid;
   logic             in_ack;
   logic             out_valid;
   logic             out_ready;
   logic             ld_pc, in_pc, ram_we, ram_re, ld_ir, reg_we;
   logic             au_en, g_en, in_en, out_en, s0;
   logic [1:0]       s;
   logic [3:0]       ac;
   logic [1:0]       SR, DR;
   logic             busy, halted, io_err;
   logic [CNT_W-1:0] instr_cnt;

   typedef struct packed {
      logic       ld_pc, in_pc, ram_we, ram_re, ld_ir, reg_we, au_en, g_en;
      logic       in_en, out_en, s0, in_ack, out_valid, busy, halted;
      logic [1:0] s;
      logic [3:0] ac;
      logic [1:0] sr;
      logic [1:0] dr;
   } ctl_t;

   typedef struct packed {
      logic [7:0]       tag;
      ctl_t             ctl;
      logic [CNT_W-1:0] cnt;
      logic             err;
   } exp_t;

   exp_t             exp_q[$];
   exp_t             cur;
   ctl_t             act;
   int               checks = 0;
   int               passes = 0;
   logic [CNT_W-1:0] cnt_m;
   logic             err_m;

   multicycle_ctrl #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT),
      .TMR_W   (TMR_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .step_mode (step_mode),
      .ir        (ir),
      .gf        (gf),
      .in_valid  (in_valid),
      .in_ack    (in_ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ld_pc     (ld_pc),
      .in_pc     (in_pc),
      .ram_we    (ram_we),
      .ram_re    (ram_re),
      .ld_ir     (ld_ir),
      .reg_we    (reg_we),
      .au_en     (au_en),
      .g_en      (g_en),
      .in_en     (in_en),
      .out_en    (out_en),
      .s0        (s0),
      .s         (s),
      .ac        (ac),
      .SR        (SR),
      .DR        (DR),
      .busy      (busy),
      .halted    (halted),
      .io_err    (io_err),
      .instr_cnt (instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expected record per cycle, compared mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         act = {ld_pc, in_pc, ram_we, ram_re, ld_ir, reg_we, au_en, g_en,
                in_en, out_en, s0, in_ack, out_valid, busy, halted,
                s, ac, SR, DR};
         checks++;
         if ((act === cur.ctl) && (instr_cnt === cur.cnt) && (io_err === cur.err)) begin
            passes++;
         end else begin
            $display("FAIL cycle_%c t=%0t: got ctl=%h cnt=%0d err=%b, required ctl=%h cnt=%0d err=%b",
                     cur.tag, $time, act, instr_cnt, io_err, cur.ctl, cur.cnt, cur.err);
         end
      end
   end

   // Safety net against a stuck run
   initial begin
      #2000000;
      $display("FAIL watchdog: run exceeded its time budget");
      $fatal(1);
   end

   function automatic ctl_t dflt(input logic b, input logic h);
      ctl_t c;
      c        = '0;
      c.s0     = 1'b1;
      c.busy   = b;
      c.halted = h;
      return c;
   endfunction

   task automatic push(input ctl_t c, input logic [7:0] t);
      exp_t e;
      e.tag = t;
      e.ctl = c;
      e.cnt = cnt_m;
      e.err = err_m;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic noise();
      start     = ($urandom_range(0, 1) == 1);
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 1) == 1);
   endtask

   // Waiting in PAUSE (1), HALT (2) or IDLE (3) until a start pulse
   task automatic linger(input int after);
      ctl_t       c;
      logic [7:0] t;
      if (after != 0) begin
         c = dflt(1'b0, (after == 2));
         t = (after == 1) ? "P" : ((after == 2) ? "H" : "Z");
         repeat ($urandom_range(0, 2)) begin
            noise();
            start = 1'b0;
            push(c, t);
            tick();
         end
         noise();
         start = 1'b1;
         push(c, t);
         if (after == 2) err_m = 1'b0;
         tick();
      end
   endtask

   // One instruction: dly = cycles the I/O handshake is held off
   task automatic run(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input int dly, input logic g, input logic stp, input bit abort);
      ctl_t       c;
      logic [1:0] sr;
      logic [1:0] dr;
      int         after;
      logic       hs;
      sr        = ((op == 4'hA) || (op == 4'hB) || (op == 4'h7)) ? 2'b11 : rs;
      dr        = (op == 4'hE) ? 2'b00 : ((op == 4'h7) ? 2'b11 : rd);
      gf        = g;
      step_mode = stp;
      after     = 0;
      // fetch
      noise();
      c = dflt(1'b1, 1'b0);
      c.ram_re = 1'b1; c.ld_ir = 1'b1; c.in_pc = 1'b1;
      push(c, "F");
      tick();
      // decode (datapath IR now holds the new word)
      ir = {op, rd, rs};
      noise();
      c = dflt(1'b1, 1'b0);
      c.sr = sr; c.dr = dr;
      push(c, "D");
      if (op == 4'hF) begin
         cnt_m = cnt_m + 1'b1;
         after = 2;
      end
      tick();
      if (op == 4'hF) begin
         after = 2;
      end else if ((op == 4'hC) || (op == 4'hD)) begin
         for (int k = 0; k < TIMEOUT; k++) begin
            noise();
            hs = (k >= dly);
            c  = dflt(1'b1, 1'b0);
            c.sr = sr; c.dr = dr;
            if (op == 4'hC) begin
               in_valid = hs;
               c.reg_we = hs; c.in_en = hs; c.in_ack = hs;
               push(c, "I");
            end else begin
               out_ready = hs;
               c.au_en = 1'b1; c.ac = 4'b0100; c.out_en = 1'b1; c.out_valid = 1'b1;
               push(c, "O");
            end
            if (hs) begin
               cnt_m = cnt_m + 1'b1;
               after = stp ? 1 : 0;
               tick();
               break;
            end
            if (k == TIMEOUT - 1) begin
               err_m = 1'b1;
               after = 2;
            end
            tick();
         end
      end else begin
         noise();
         c = dflt(1'b1, 1'b0);
         c.sr = sr; c.dr = dr;
         case (op)
            4'h4: begin c.au_en = 1'b1; c.ac = 4'b0100; c.reg_we = 1'b1; end
            4'h5: begin c.au_en = 1'b1; c.ac = 4'b0100; c.s = 2'b10; c.ram_we = 1'b1; end
            4'h6: begin c.s = 2'b01; c.ram_re = 1'b1; c.reg_we = 1'b1; end
            4'h7: begin c.s0 = 1'b0; c.reg_we = 1'b1; end
            4'h8: begin c.au_en = 1'b1; c.ac = 4'b1000; c.reg_we = 1'b1; end
            4'h9: begin c.au_en = 1'b1; c.ac = 4'b1001; c.reg_we = 1'b1; c.g_en = 1'b1; end
            4'hA: c.ld_pc = 1'b1;
            4'hB: c.ld_pc = g;
            4'hE: begin c.ram_re = 1'b1; c.in_pc = 1'b1; c.reg_we = 1'b1; end
            default: c.ld_pc = 1'b0;
         endcase
         if (abort) begin
            #1 rst_n = 1'b0;
            cnt_m = '0;
            err_m = 1'b0;
            push(dflt(1'b0, 1'b0), "X");
            tick();
            push(dflt(1'b0, 1'b0), "R");
            tick();
            rst_n = 1'b1;
            after = 3;
         end else begin
            push(c, "E");
            cnt_m = cnt_m + 1'b1;
            after = stp ? 1 : 0;
            tick();
         end
      end
      linger(after);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; gf = 1'b0;
      ir = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
      cnt_m = '0;
      err_m = 1'b0;
      @(posedge clk);
      #1;
      repeat (2) begin
         push(dflt(1'b0, 1'b0), "R");
         tick();
      end
      rst_n = 1'b1;
      linger(3);

      // directed program
      run(4'hE, 2'd1, 2'd2, 0, 1'b0, 1'b0, 1'b0);        // MOVI
      run(4'h8, 2'd1, 2'd0, 0, 1'b0, 1'b0, 1'b0);        // ADD
      run(4'h9, 2'd2, 2'd3, 0, 1'b1, 1'b0, 1'b0);        // SUB, gf=1
      run(4'hB, 2'd0, 2'd1, 0, 1'b1, 1'b0, 1'b0);        // JG taken
      run(4'h9, 2'd2, 2'd3, 0, 1'b0, 1'b0, 1'b0);        // SUB, gf=0
      run(4'hB, 2'd0, 2'd1, 0, 1'b0, 1'b0, 1'b0);        // JG not taken
      run(4'hA, 2'd1, 2'd0, 0, 1'b0, 1'b0, 1'b0);        // JMP
      run(4'h7, 2'd0, 2'd1, 0, 1'b0, 1'b0, 1'b0);        // MOVD
      run(4'h5, 2'd2, 2'd1, 0, 1'b0, 1'b0, 1'b0);        // MOVB
      run(4'h6, 2'd1, 2'd2, 0, 1'b0, 1'b0, 1'b0);        // MOVC
      run(4'h2, 2'd3, 2'd3, 0, 1'b0, 1'b0, 1'b0);        // NOP
      run(4'hC, 2'd2, 2'd0, 4, 1'b0, 1'b0, 1'b0);        // IN, valid in the expiring cycle
      run(4'hC, 2'd1, 2'd0, 0, 1'b0, 1'b0, 1'b0);        // IN, immediate
      run(4'hD, 2'd0, 2'd3, TIMEOUT + 1, 1'b0, 1'b0, 1'b0); // OUT timeout
      run(4'hD, 2'd0, 2'd2, 2, 1'b0, 1'b0, 1'b0);        // OUT after 2 cycles
      repeat (3) run(4'h4, 2'd1, 2'd2, 0, 1'b0, 1'b1, 1'b0); // MOVA, single-step
      run(4'hF, 2'd0, 2'd0, 0, 1'b0, 1'b0, 1'b0);        // HALT

      // random program
      repeat (150) begin
         run(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             int'($urandom_range(0, TIMEOUT + 1)), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 3) == 0), 1'b0);
      end

      // reset during a MOVB execute cycle, then resume from zero
      run(4'h5, 2'd1, 2'd2, 0, 1'b0, 1'b0, 1'b1);
      run(4'h4, 2'd0, 2'd1, 0, 1'b0, 1'b0, 1'b0);
      run(4'h8, 2'd3, 2'd2, 0, 1'b0, 1'b0, 1'b0);

      for (int n = 0; (n < 10) && (exp_q.size() > 0); n++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expected cycles unchecked, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the 8-bit model machine. It replaces the two-phase sm-driven controller with an explicit FETCH/DECODE/EXEC state machine, and it issues the same datapath control set: PC, RAM, IR, register file, AU and G flag. It adds run control (start, single-step, halt), ready/valid handshakes for IN/OUT, an I/O timeout and a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)
TIMEOUT, 255, max cycles spent in an I/O wait state; 0 disables the timeout
TMR_W, 8, width of the I/O wait timer (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run/continue pulse (level-sampled each cycle)
step_mode  in  1  1 = pause after every retired instruction
ir  in  8  datapath IR contents (opcode ir[7:4], Rd ir[3:2], Rs ir[1:0])
gf  in  1  G flag from datapath
in_valid  in  1  external input data valid
in_ack  out  1  input accepted (1-cycle pulse)
out_valid  out  1  output data valid on datapath bus
out_ready  in  1  external sink accepts output
ld_pc, in_pc, ram_we, ram_re, ld_ir, reg_we, au_en, g_en, in_en, out_en, s0  out  1 each  datapath controls
s  out  2  RAM address select (00 PC, 01 Rs-indirect read, 10 Rd-indirect write)
ac  out  4  AU function (1000 ADD, 1001 SUB, 0100 pass)
SR, DR  out  2 each  register source/destination select
busy  out  1  1 in FETCH/DECODE/EXEC/IN_WAIT/OUT_WAIT
halted  out  1  1 in HALT
io_err  out  1  sticky I/O timeout flag
instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, instr_cnt=0, io_err=0, wait timer=0.
- All 1-bit controls are 0 except s0=1. s=00, ac=0000, SR=DR=00. These defaults hold in every state unless listed below.
- IDLE: waits for start=1, then goes to FETCH.
- FETCH (1 cycle): ram_re=1, s=00, ld_ir=1, in_pc=1. Next state DECODE.
- DECODE (1 cycle): no strobes. SR/DR are driven from ir from here through the end of the instruction:
  - SR=11 for JMP, JG and MOVD; otherwise SR=Rs.
  - DR=00 for MOVI, DR=11 for MOVD; otherwise DR=Rd.
  - Next state: IN_WAIT for IN, OUT_WAIT for OUT, HALT for HALT, EXEC for everything else.
- EXEC (1 cycle), by opcode:
  - MOVA 0100: au_en, ac=0100, reg_we.
  - MOVB 0101: au_en, ac=0100, s=10, ram_we.
  - MOVC 0110: s=01, ram_re, reg_we.
  - MOVD 0111: s0=0, reg_we.
  - ADD 1000: au_en, ac=1000, reg_we.
  - SUB 1001: au_en, ac=1001, reg_we, g_en.
  - JMP 1010: ld_pc.
  - JG 1011: ld_pc=gf, with gf sampled this cycle.
  - MOVI 1110: ram_re, s=00, in_pc, reg_we.
  - Opcodes 0000-0011: NOP, no strobes.
- After EXEC: go to PAUSE if step_mode=1, else FETCH. instr_cnt increments by 1.
- IN_WAIT: timer counts each cycle.
  - When in_valid=1 in the same cycle: reg_we=1, in_en=1, in_ack=1, instr_cnt increments, then go to FETCH or PAUSE.
- OUT_WAIT: au_en=1, ac=0100, out_en=1, out_valid=1 held every cycle.
  - When out_ready=1: instr_cnt increments, then go to FETCH or PAUSE.
  - The transfer completes in the cycle out_valid and out_ready are both 1.
- Timeout (TIMEOUT>0): if the timer reaches TIMEOUT without a handshake, set io_err=1 and go to HALT.
  - The instruction does not retire and no strobe is issued.
  - The timer clears on every entry to an I/O wait state.
  - If the handshake and the timeout happen in the same cycle, the handshake wins.
- PAUSE: no strobes; busy=0. start=1 goes to FETCH.
- HALT: no strobes; halted=1.
  - Entering HALT via the HALT opcode increments instr_cnt.
  - start=1 goes to FETCH (PC has already advanced past the HALT) and clears io_err.
- start is ignored in any state other than IDLE, PAUSE and HALT.
- step_mode is sampled at instruction completion.
- instr_cnt wraps from all-ones to 0.
- Latency: 3 cycles per non-I/O instruction; 3 + wait cycles for IN/OUT.
- Reset asserted mid-instruction aborts immediately: no further strobes, back to IDLE.

Decomposition:
- Package mc_pkg holds: the opcode localparams (MOVA..HALT), the state encoding (IDLE, FETCH, DECODE, EXEC, IN_WAIT, OUT_WAIT, PAUSE, HALT), the AC_ADD/AC_SUB/AC_PASS codes and the S_PC/S_RS/S_RD select codes.
- One sub-module, io_wait_timer: clear/enable inputs, TMR_W counter, expired output.

Test Plan:
- Reset then start; program MOVI R0,#5 then ADD R1,R0 -> FETCH/DECODE/EXEC every 3 cycles; MOVI EXEC has reg_we=1, DR=00, in_pc=1; ADD EXEC has ac=1000; instr_cnt=2.
- SUB with gf=1 followed by JG -> g_en=1 in SUB EXEC; ld_pc=1 and SR=11 in JG EXEC. Repeat with gf=0 -> ld_pc=0.
- IN with in_valid asserted 4 cycles after IN_WAIT entry -> in_ack/reg_we/in_en pulse exactly once in that cycle; instr_cnt increments by 1.
- OUT with out_ready held low, TIMEOUT=3 -> out_valid high for 3 cycles, then io_err=1 and halted=1, instr_cnt unchanged. start -> io_err=0, busy=1.
- step_mode=1, three MOVA instructions -> PAUSE after each; no FETCH until a start pulse; instr_cnt=3 after three pulses.
- rst_n pulled low during a MOVB EXEC cycle -> ram_we drops asynchronously; state=IDLE, instr_cnt=0.
